// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path among N_REQ word producers.
// Grants a requester, strobes the UART, then follows ready low/high through one frame.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 9,
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_request_tx,
    output logic [DATA_W-1:0]       o_uart_data,
    input  logic                    i_uart_ready,
    output logic                    o_busy,
    output logic                    o_timeout,
    output logic [CNT_W-1:0]        o_tx_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]                     r_state;
    logic [IDX_W-1:0]               r_last;
    logic [TO_W-1:0]                r_to_cnt;

    logic [N_REQ-1:0][DATA_W-1:0]   w_words;
    logic [IDX_W-1:0]               w_pick;
    logic                           w_found;
    logic [SUM_W-1:0]               w_sum;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_words[g] = i_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Search upward from the slot after the last winner, wrapping at N_REQ.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_sum = {1'b0, r_last} + SUM_W'(i);
            if (w_sum >= SUM_W'(N_REQ))
                w_sum = w_sum - SUM_W'(N_REQ);
            if (!w_found && i_req[w_sum[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_last       <= IDX_W'(N_REQ - 1);
            r_to_cnt     <= '0;
            o_grant      <= '0;
            o_request_tx <= 1'b0;
            o_uart_data  <= '0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
            o_tx_count   <= '0;
        end else begin
            o_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_uart_ready && w_found) begin
                        r_state      <= S_LAUNCH;
                        r_last       <= w_pick;
                        o_grant      <= N_REQ'(1) << w_pick;
                        o_request_tx <= 1'b1;
                        o_uart_data  <= w_words[w_pick];
                        o_busy       <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    o_grant      <= '0;
                    o_request_tx <= 1'b0;
                    r_to_cnt     <= '0;
                    r_state      <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A UART that never drops ready would otherwise lock the arbiter.
                    if (!i_uart_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_uart_ready) begin
                        o_tx_count <= o_tx_count + 1'b1;
                        o_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a transaction-level UART and round-robin
// model predict each grant, word, timeout and frame count.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 9;
    localparam int BT = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data;
    logic            ready;
    logic [N-1:0]    grant;
    logic            rtx;
    logic [DW-1:0]   udata;
    logic            busy;
    logic            tmo;
    logic [CW-1:0]   txc;
    logic [DW-1:0]   wd [N];

    always #5 clk = ~clk;

    always_comb begin
        data = '0;
        for (int k = 0; k < N; k++) data[k*DW +: DW] = wd[k];
    end

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TIMEOUT(BT), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
        .o_grant(grant), .o_request_tx(rtx), .o_uart_data(udata),
        .i_uart_ready(ready), .o_busy(busy), .o_timeout(tmo), .o_tx_count(txc)
    );

    int errors = 0, checks = 0;
    int exp_last = N - 1, frames = 0, cyc = 0, last_strobe = -100, exp_to_cyc = -1;
    int pre = 0, ulen = 0, g_idx = -1;
    bit saw = 1'b0, dead = 1'b0, rand_dead = 1'b0, force_low = 1'b0;
    logic [DW-1:0] rxq[$];
    int gq[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) if (r[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    task automatic drive_ready();
        ready = force_low ? 1'b0 : ((pre > 0) || (ulen == 0));
    endtask

    // One clock: observe registered outputs, score them, advance the UART model.
    task automatic step();
        int e;
        @(posedge clk);
        #1;
        cyc++;
        g_idx = -1;
        saw = rtx;
        if (rtx) begin
            e = rr_pick(req, exp_last);
            chk("grant", grant, (e < 0) ? 0 : (1 << e));
            chk("data", udata, (e < 0) ? 0 : wd[e]);
            chk("busy_launch", busy, 1);
            chk("tx_count", txc, frames % (1 << CW));
            chk("spacing", (cyc - last_strobe) >= 4, 1);
            if (e >= 0) exp_last = e;
            g_idx = e;
            last_strobe = cyc;
            rxq.push_back(udata);
            gq.push_back(e);
            if (dead || (rand_dead && $urandom_range(0, 9) == 0))
                exp_to_cyc = cyc + BT + 1;
            else begin
                pre  = $urandom_range(0, 5);
                ulen = $urandom_range(3, 8);
            end
        end else begin
            chk("idle_grant", grant, 0);
            if (pre > 0) pre--;
            else if (ulen > 0) begin
                ulen--;
                if (ulen == 0) frames++;
            end
        end
        chk("timeout", tmo, cyc == exp_to_cyc);
        drive_ready();
    endtask

    task automatic wait_strobe(input int maxc);
        int n = 0;
        do begin
            step();
            n++;
        end while (!saw && n < maxc);
        chk("strobe_seen", saw, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy == 1'b0 && pre == 0 && ulen == 0) && n < 100) begin
            step();
            n++;
        end
        chk("idle_reached", busy == 1'b0 && pre == 0 && ulen == 0, 1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_rtx", rtx, 0);
        chk("rst_data", udata, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_cnt", txc, 0);
        chk("rst_busy", busy, 0);
        exp_last = N - 1; frames = 0; pre = 0; ulen = 0;
        exp_to_cyc = -1; last_strobe = -100; dead = 1'b0; force_low = 1'b0;
        drive_ready();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, t, n;
        for (int k = 0; k < N; k++) wd[k] = '0;
        drive_ready();
        do_reset();

        // single requester, normal handshake
        wd[0] = 9'h0A5;
        req = 4'b0001;
        wait_strobe(5);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_data", udata, 9'h0A5);
        req = '0;
        wait_idle();
        chk("t1_count", txc, 1);

        // all requesters held: rotation from reset, loopback words
        do_reset();
        rxq.delete();
        gq.delete();
        for (int k = 0; k < N; k++) wd[k] = DW'(9'h100 + k);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_strobe(60);
        req = '0;
        wait_idle();
        chk("t2_count", txc, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_order", gq[i], i % 4);
            chk("t2_word", rxq[i], 9'h100 + (i % 4));
        end

        // after requester 2 wins, 0 beats 2 when both pending
        req = 4'b0100;
        wait_strobe(10);
        chk("t3_first", grant, 4'b0100);
        req = '0;
        wait_idle();
        req = 4'b0101;
        wait_strobe(10);
        chk("t3_next", grant, 4'b0001);
        req = '0;
        wait_idle();

        // UART never goes busy
        dead = 1'b1;
        req = 4'b0010;
        wait_strobe(10);
        s = cyc;
        n = 0;
        do begin
            step();
            n++;
        end while (!tmo && n < 30);
        chk("t4_delay", cyc - s, BT + 1);
        dead = 1'b0;
        wait_strobe(3);
        chk("t4_regrant", cyc - s, BT + 2);
        chk("t4_grant", grant, 4'b0010);
        req = '0;
        wait_idle();

        // ready low in idle holds off the grant
        force_low = 1'b1;
        drive_ready();
        req = 4'b0001;
        repeat (5) begin
            step();
            chk("t5_hold", rtx, 0);
        end
        force_low = 1'b0;
        drive_ready();
        t = cyc;
        wait_strobe(5);
        chk("t5_latency", cyc - t, 1);
        req = '0;
        wait_idle();

        // reset mid-frame
        req = 4'b0100;
        wait_strobe(10);
        req = '0;
        n = 0;
        do begin
            step();
            n++;
        end while (!(pre == 0 && ulen > 0) && n < 10);
        step();
        chk("t6_busy", busy, 1);
        do_reset();
        req = 4'b1111;
        wait_strobe(5);
        chk("t6_grant", grant, 4'b0001);
        req = '0;
        wait_idle();

        // random traffic with occasional dead frames; count wraps at 2^CW
        rand_dead = 1'b1;
        for (int it = 0; it < 1500; it++) begin
            step();
            if (req != '0) chk("starve", (cyc - last_strobe) <= 60, 1);
            for (int k = 0; k < N; k++) begin
                if (g_idx == k) begin
                    if ($urandom_range(0, 1) == 1) req[k] = 1'b0;
                    wd[k] = DW'($urandom);
                end else if (!req[k] && $urandom_range(0, 7) == 0) begin
                    req[k] = 1'b1;
                    wd[k] = DW'($urandom);
                end
            end
        end
        rand_dead = 1'b0;
        req = '0;
        wait_idle();
        chk("final_count", txc, frames % (1 << CW));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single transmit path of uart_top between N_REQ independent requesters.
- Selects one pending requester and captures its word.
- Drives uart_top's request-to-send strobe and data bus.
- Tracks the UART ready handshake through a full frame before granting again.
- Sits between on-chip word producers and uart_top's i_request_tx / i_data / o_ready pins.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 9, word width, matches uart_top data bus
BUSY_TIMEOUT, 16, cycles allowed for UART ready to drop after a request strobe
CNT_W, 16, width of completed-word counter

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  N_REQ  per-requester request; hold high with data stable until granted
i_data  in  N_REQ*DATA_W  packed words; requester k occupies bits [k*DATA_W +: DATA_W]
o_grant  out  N_REQ  one-hot, one-cycle pulse: requester's word captured
o_request_tx  out  1  one-cycle send strobe to uart_top i_request_tx
o_uart_data  out  DATA_W  registered word to uart_top i_data
i_uart_ready  in  1  uart_top o_ready
o_busy  out  1  high whenever state != IDLE
o_timeout  out  1  one-cycle pulse: UART never went busy after a strobe
o_tx_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-low. While i_rst_n=0:
  - o_grant=0, o_request_tx=0, o_uart_data=0, o_timeout=0, o_tx_count=0, o_busy=0.
  - state=IDLE, last-grant pointer=N_REQ-1, so requester 0 has highest priority first.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Decision edge: i_uart_ready=1 and i_req!=0.
  - At that edge, pick the first set i_req bit searching upward from (last+1) mod N_REQ.
  - Capture that requester's slice into o_uart_data, set o_grant[k]=1, update last=k, go to LAUNCH.
  - If i_uart_ready=0, stay in IDLE with no grant, regardless of i_req.
- LAUNCH (exactly one cycle):
  - o_grant[k]=1 and o_request_tx=1 in this same cycle; both clear on exit.
  - Clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - When i_uart_ready=0 is sampled, go to WAIT_DONE.
  - Otherwise increment the counter.
  - If the counter reaches BUSY_TIMEOUT-1 while i_uart_ready is still 1: pulse o_timeout for one cycle, go to IDLE, leave o_tx_count unchanged.
- WAIT_DONE:
  - When i_uart_ready=1 is sampled, increment o_tx_count and go to IDLE.
  - No timeout in this state; frame length is set by the UART configuration.
- Minimum spacing between consecutive o_request_tx strobes is 4 cycles (LAUNCH, WAIT_BUSY≥1, WAIT_DONE≥1, IDLE decision).
- i_req is sampled only in IDLE. Changes in other states are ignored.
- A requester still high after its grant is eligible again, but only after all other pending requesters (round-robin fairness).
- o_uart_data holds the captured word until the next grant.
- Reset asserted mid-frame returns to IDLE immediately. The UART must be reset alongside; no frame completion is counted.
- o_tx_count wraps from 2^CNT_W-1 to 0.

Test Plan:
1. Reset, then i_req=0001, data0=0x0A5, ready handshake normal
   -> grant=0001 and request_tx pulse in the same single cycle, o_uart_data=0x0A5, o_tx_count=1 after ready returns.
2. i_req=1111 held continuously, data k=0x100+k, UART in loopback
   -> grants in order 0,1,2,3,0; loopback RX words 0x100,0x101,0x102,0x103,0x100; o_tx_count=5.
3. After granting requester 2, raise i_req=0101 in IDLE -> next grant is requester 0, not 2.
4. i_uart_ready forced to 1 permanently, i_req=0010
   -> one request_tx pulse, o_timeout pulses exactly 16 cycles after entering WAIT_BUSY, o_tx_count unchanged, next grant follows.
5. i_uart_ready=0 in IDLE with i_req=0001
   -> no grant until ready=1, then grant on the first edge with ready=1.
6. Assert i_rst_n=0 during WAIT_DONE
   -> all outputs 0 asynchronously, o_busy=0, after release first grant goes to requester 0.
